acq_sequencer: RTL and testbench
================================

ACQ_SEQUENCER -- requirements
Module: acq_sequencer

Interface
REQ-001 The module SHALL have parameter FRAME_LEN, default 1024, giving the number of time samples per frame.
REQ-002 The module SHALL have parameter ADDR_W, default 10, giving the time-buffer address width; FRAME_LEN SHALL NOT exceed 2**ADDR_W.
REQ-003 The module SHALL have parameter FFT_TIMEOUT, default 65535, giving the clk cycles allowed in FFT_WAIT.
REQ-004 The module SHALL have these ports:
- clk  in  1  system clock (100 MHz); one clock domain only.
- reset  in  1  synchronous, active-high reset.
- start_i  in  1  one-cycle acquisition request (10 Hz tick).
- sample_valid_i  in  1  mic sample strobe.
- fft_done_i  in  1  FFT completion pulse.
- capture_en_o  out  1  time-buffer port enable.
- we_o  out  1  time-buffer write enable.
- waddr_o  out  ADDR_W  time-buffer write address.
- fft_start_o  out  1  one-cycle FFT trigger.
- frame_ready_o  out  1  one-cycle frame-complete pulse to the image controller.
- busy_o  out  1  high whenever state is not IDLE.
- timeout_o  out  1  one-cycle FFT timeout pulse.
- overrun_cnt_o  out  8  count of ignored start requests.

Function
REQ-005 The FSM SHALL have states IDLE, CAPTURE, FFT_START, FFT_WAIT and DONE, all registered.
REQ-006 IDLE: start_i=1 SHALL move to CAPTURE and load waddr_o=0 on the next edge.
REQ-007 CAPTURE: capture_en_o SHALL be 1 and we_o SHALL equal sample_valid_i combinationally, with zero latency.
REQ-008 CAPTURE: each sample_valid_i=1 SHALL increment waddr_o by 1 on the next edge.
REQ-009 CAPTURE: sample_valid_i=1 with waddr_o=FRAME_LEN-1 SHALL write that last sample, wrap waddr_o to 0 and move to FFT_START.
REQ-010 FFT_START SHALL assert fft_start_o for exactly one cycle, clear the timeout counter and move to FFT_WAIT.
REQ-011 FFT_WAIT: fft_done_i=1 SHALL move to DONE.
REQ-012 FFT_WAIT: when the timeout counter reaches FFT_TIMEOUT-1 without fft_done_i, timeout_o SHALL pulse for one cycle and the FSM SHALL move to IDLE.
REQ-013 fft_done_i and timeout in the same cycle SHALL be treated as done, with no timeout pulse.
REQ-014 DONE SHALL assert frame_ready_o for exactly one cycle and move to IDLE.
REQ-015 start_i=1 in any state other than IDLE SHALL be ignored and SHALL increment overrun_cnt_o, saturating at 255.
REQ-016 fft_done_i outside FFT_WAIT SHALL be ignored.
REQ-017 Outside CAPTURE, capture_en_o and we_o SHALL be 0 and waddr_o SHALL hold its value.
REQ-018 The timeout counter SHALL be wide enough for FFT_TIMEOUT and SHALL NOT wrap.
REQ-019 All outputs except we_o SHALL be driven directly from registers.

Reset
REQ-020 reset=1 SHALL take effect on the next clk edge and override all other inputs, including mid-capture and mid-FFT_WAIT.
REQ-021 Reset values: state IDLE; waddr_o 0; overrun_cnt_o 0; timeout counter 0; all 1-bit outputs 0.
REQ-022 A start_i coincident with reset SHALL be ignored and SHALL NOT be counted.

Structure
REQ-023 The state encoding and default FRAME_LEN, ADDR_W and FFT_TIMEOUT constants SHALL live in the shared project package, audio_pkg.
REQ-024 The module SHALL be a single flat module with no sub-modules, instantiated in the top level between the 10 Hz flag generator, the FFT block and the image controller.

Verification
REQ-025 Nominal frame, FRAME_LEN=1024: start_i pulse, then 1024 sample_valid_i pulses spaced 20 cycles, then fft_done_i 100 cycles after fft_start_o:
- we_o high on exactly 1024 cycles, addresses 0..1023.
- fft_start_o high one cycle after the 1024th write.
- frame_ready_o high one cycle after fft_done_i.
- busy_o returns to 0.
REQ-026 Overrun: 3 start_i pulses during CAPTURE and 1 during FFT_WAIT -> overrun_cnt_o=4 and the frame completes normally; 300 extra pulses -> overrun_cnt_o=255.
REQ-027 Timeout, FFT_TIMEOUT=16: fft_done_i withheld -> timeout_o pulses 16 cycles after entering FFT_WAIT, state becomes IDLE and frame_ready_o never asserts.
REQ-028 Reset mid-capture: reset after 500 samples -> next cycle state IDLE, waddr_o=0, we_o=0; the following start_i captures from address 0.
REQ-029 Boundary: back-to-back sample_valid_i every cycle at FRAME_LEN=4 -> addresses 0,1,2,3 written and fft_start_o on the cycle after address 3; stray fft_done_i in IDLE causes no output change.

Source files
------------

// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared audio project types and default constants
package audio_pkg;

  localparam int ACQ_FRAME_LEN   = 1024;
  localparam int ACQ_ADDR_W      = 10;
  localparam int ACQ_FFT_TIMEOUT = 65535;

  typedef enum logic [2:0] {
    ACQ_IDLE      = 3'd0,
    ACQ_CAPTURE   = 3'd1,
    ACQ_FFT_START = 3'd2,
    ACQ_FFT_WAIT  = 3'd3,
    ACQ_DONE      = 3'd4
  } acq_state_e;

endpackage

// File: rtl/acq_sequencer.sv
// rtl/acq_sequencer.sv - frame acquisition sequencer: capture samples, kick FFT, signal frame ready
// Flat FSM; every output except we_o comes straight from a register.
module acq_sequencer
  import audio_pkg::*;
#(
  parameter int FRAME_LEN   = ACQ_FRAME_LEN,
  parameter int ADDR_W      = ACQ_ADDR_W,
  parameter int FFT_TIMEOUT = ACQ_FFT_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic              sample_valid_i,
  input  logic              fft_done_i,
  output logic              capture_en_o,
  output logic              we_o,
  output logic [ADDR_W-1:0] waddr_o,
  output logic              fft_start_o,
  output logic              frame_ready_o,
  output logic              busy_o,
  output logic              timeout_o,
  output logic [7:0]        overrun_cnt_o
);

  localparam int TCNT_W = $clog2(FFT_TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(FFT_TIMEOUT - 1);

  acq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;
  logic [7:0]        ovr_q, ovr_d;
  logic              timeout_q, timeout_d;
  logic              capture_en_q, fft_start_q, frame_ready_q, busy_q;

  always_comb begin
    state_d   = state_q;
    waddr_d   = waddr_q;
    tcnt_d    = tcnt_q;
    ovr_d     = ovr_q;
    timeout_d = 1'b0;

    if (start_i && (state_q != ACQ_IDLE) && (ovr_q != 8'hFF)) begin
      ovr_d = ovr_q + 8'd1;
    end

    case (state_q)
      ACQ_IDLE: begin
        if (start_i) begin
          state_d = ACQ_CAPTURE;
          waddr_d = '0;
        end
      end
      ACQ_CAPTURE: begin
        if (sample_valid_i) begin
          if (waddr_q == LAST_ADDR) begin
            waddr_d = '0;
            state_d = ACQ_FFT_START;
          end else begin
            waddr_d = waddr_q + 1'b1;
          end
        end
      end
      ACQ_FFT_START: begin
        tcnt_d  = '0;
        state_d = ACQ_FFT_WAIT;
      end
      ACQ_FFT_WAIT: begin
        // A done arriving on the last allowed cycle wins over the timeout.
        if (fft_done_i) begin
          state_d = ACQ_DONE;
        end else if (tcnt_q == TCNT_LAST) begin
          timeout_d = 1'b1;
          state_d   = ACQ_IDLE;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      ACQ_DONE: begin
        state_d = ACQ_IDLE;
      end
      default: begin
        state_d = ACQ_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ACQ_IDLE;
      waddr_q       <= '0;
      tcnt_q        <= '0;
      ovr_q         <= '0;
      timeout_q     <= 1'b0;
      capture_en_q  <= 1'b0;
      fft_start_q   <= 1'b0;
      frame_ready_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      waddr_q       <= waddr_d;
      tcnt_q        <= tcnt_d;
      ovr_q         <= ovr_d;
      timeout_q     <= timeout_d;
      capture_en_q  <= (state_d == ACQ_CAPTURE);
      fft_start_q   <= (state_d == ACQ_FFT_START);
      frame_ready_q <= (state_d == ACQ_DONE);
      busy_q        <= (state_d != ACQ_IDLE);
    end
  end

  assign capture_en_o  = capture_en_q;
  assign we_o          = capture_en_q & sample_valid_i;
  assign waddr_o       = waddr_q;
  assign fft_start_o   = fft_start_q;
  assign frame_ready_o = frame_ready_q;
  assign busy_o        = busy_q;
  assign timeout_o     = timeout_q;
  assign overrun_cnt_o = ovr_q;

endmodule

// File: tb/tb_acq_sequencer.sv
// tb/tb_acq_sequencer.sv - randomized and directed bench for acq_sequencer
// Two instances: a full-size frame (index 0) and a 4-sample frame with short timeout (index 1).
module tb_acq_sequencer;

  localparam int M_IDLE = 0;
  localparam int M_CAP  = 1;
  localparam int M_FS   = 2;
  localparam int M_WAIT = 3;
  localparam int M_DONE = 4;

  typedef struct {
    int ph;
    int addr;
    int waited;
    int ovr;
    int to;
  } model_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst [2];
  logic st  [2];
  logic sv  [2];
  logic dn  [2];

  logic       cap_en [2];
  logic       we     [2];
  logic       fs     [2];
  logic       fr     [2];
  logic       busy   [2];
  logic       to     [2];
  logic [7:0] ovr    [2];
  logic [9:0] waddr_n;
  logic [1:0] waddr_s;
  logic [9:0] waddr  [2];
  assign waddr[0] = waddr_n;
  assign waddr[1] = {8'd0, waddr_s};

  acq_sequencer #(.FRAME_LEN(1024), .ADDR_W(10), .FFT_TIMEOUT(200)) u_nom (
    .clk(clk), .reset(rst[0]), .start_i(st[0]), .sample_valid_i(sv[0]), .fft_done_i(dn[0]),
    .capture_en_o(cap_en[0]), .we_o(we[0]), .waddr_o(waddr_n), .fft_start_o(fs[0]),
    .frame_ready_o(fr[0]), .busy_o(busy[0]), .timeout_o(to[0]), .overrun_cnt_o(ovr[0])
  );

  acq_sequencer #(.FRAME_LEN(4), .ADDR_W(2), .FFT_TIMEOUT(16)) u_small (
    .clk(clk), .reset(rst[1]), .start_i(st[1]), .sample_valid_i(sv[1]), .fft_done_i(dn[1]),
    .capture_en_o(cap_en[1]), .we_o(we[1]), .waddr_o(waddr_s), .fft_start_o(fs[1]),
    .frame_ready_o(fr[1]), .busy_o(busy[1]), .timeout_o(to[1]), .overrun_cnt_o(ovr[1])
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit chk_en  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int flen_of(int d);
    return (d == 0) ? 1024 : 4;
  endfunction

  function automatic int tmo_of(int d);
    return (d == 0) ? 200 : 16;
  endfunction

  task automatic chk(string nm, int d, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s dut%0d cyc=%0d actual=%0d expected=%0d", nm, d, cyc, act, exp);
    end
  endtask

  // Reference: frame progress as phase + samples taken + cycles spent waiting on the FFT.
  function automatic model_t mstep(model_t m, bit r, bit s, bit v, bit d, int flen, int tmo);
    model_t n;
    n = m;
    n.to = 0;
    if (r) begin
      n = '{default: 0};
      return n;
    end
    if (s && m.ph != M_IDLE) n.ovr = (m.ovr < 255) ? m.ovr + 1 : 255;
    case (m.ph)
      M_IDLE: if (s) begin n.ph = M_CAP; n.addr = 0; end
      M_CAP: if (v) begin
        n.addr = (m.addr + 1) % flen;
        if (m.addr + 1 == flen) n.ph = M_FS;
      end
      M_FS: begin n.ph = M_WAIT; n.waited = 0; end
      M_WAIT: begin
        if (d) n.ph = M_DONE;
        else if (m.waited + 1 >= tmo) begin n.ph = M_IDLE; n.to = 1; end
        else n.waited = m.waited + 1;
      end
      default: n.ph = M_IDLE;
    endcase
    return n;
  endfunction

  model_t mdl [2];
  initial begin
    mdl[0] = '{default: 0};
    mdl[1] = '{default: 0};
  end

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++)
      mdl[d] <= mstep(mdl[d], rst[d], st[d], sv[d], dn[d], flen_of(d), tmo_of(d));
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        chk("busy",        d, int'(busy[d]),   int'(mdl[d].ph != M_IDLE));
        chk("capture_en",  d, int'(cap_en[d]), int'(mdl[d].ph == M_CAP));
        chk("we",          d, int'(we[d]),     int'(mdl[d].ph == M_CAP && sv[d]));
        chk("waddr",       d, int'(waddr[d]),  mdl[d].addr);
        chk("fft_start",   d, int'(fs[d]),     int'(mdl[d].ph == M_FS));
        chk("frame_ready", d, int'(fr[d]),     int'(mdl[d].ph == M_DONE));
        chk("timeout",     d, int'(to[d]),     mdl[d].to);
        chk("overrun",     d, int'(ovr[d]),    mdl[d].ovr);
      end
    end
  end

  // Event log for the directed checks.
  int wr_cnt [2], addr_bad [2], last_wr_cyc [2];
  int fs_cnt [2], fs_cyc [2], fr_cnt [2], fr_cyc [2], to_cnt [2], to_cyc [2];

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (we[d]) begin
        if (int'(waddr[d]) != wr_cnt[d] % flen_of(d)) addr_bad[d]++;
        wr_cnt[d]++;
        last_wr_cyc[d] = cyc;
      end
      if (fs[d]) begin fs_cnt[d]++; fs_cyc[d] = cyc; end
      if (fr[d]) begin fr_cnt[d]++; fr_cyc[d] = cyc; end
      if (to[d]) begin to_cnt[d]++; to_cyc[d] = cyc; end
    end
  end

  task automatic clr_log(int d);
    wr_cnt[d] = 0; addr_bad[d] = 0; last_wr_cyc[d] = -1;
    fs_cnt[d] = 0; fs_cyc[d] = -1; fr_cnt[d] = 0; fr_cyc[d] = -1;
    to_cnt[d] = 0; to_cyc[d] = -1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog cyc=%0d actual=running expected=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int done_cyc;
    logic [9:0] w_before;

    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; st[d] = 1'b1; sv[d] = 1'b0; dn[d] = 1'b0;
      clr_log(d);
    end
    step();
    chk_en = 1'b1;
    step();
    for (int d = 0; d < 2; d++) begin rst[d] = 1'b0; st[d] = 1'b0; end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset_ovr_literal",   d, int'(ovr[d]),   0);
      chk("reset_busy_literal",  d, int'(busy[d]),  0);
      chk("reset_waddr_literal", d, int'(waddr[d]), 0);
    end
    step();

    // Nominal 1024-sample frame on dut0 with 3 starts during capture and 1 in FFT wait.
    clr_log(0);
    st[0] = 1'b1; step(); st[0] = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      for (int k = 0; k < 19; k++) begin
        st[0] = (k == 0 && (i == 100 || i == 200 || i == 300));
        step();
      end
      st[0] = 1'b0;
      sv[0] = 1'b1; step(); sv[0] = 1'b0;
    end
    step();
    for (int k = 0; k < 99; k++) begin
      st[0] = (k == 50);
      step();
    end
    st[0] = 1'b0;
    done_cyc = cyc;
    dn[0] = 1'b1; step(); dn[0] = 1'b0;
    step(); step();
    chk("nom_writes_literal",   0, wr_cnt[0],   1024);
    chk("nom_addr_order",       0, addr_bad[0], 0);
    chk("nom_fft_start_cyc",    0, fs_cyc[0],   last_wr_cyc[0] + 1);
    chk("nom_fft_start_count",  0, fs_cnt[0],   1);
    chk("nom_frame_ready_cyc",  0, fr_cyc[0],   done_cyc + 1);
    chk("nom_frame_ready_count",0, fr_cnt[0],   1);
    chk("nom_done_gap_literal", 0, done_cyc - fs_cyc[0], 100);
    chk("nom_ovr_literal",      0, int'(ovr[0]), 4);
    chk("nom_busy_after",       0, int'(busy[0]), 0);

    // 300 more starts: the first launches a capture, the other 299 saturate the count.
    for (int k = 0; k < 300; k++) begin st[0] = 1'b1; step(); end
    st[0] = 1'b0; step();
    chk("ovr_saturate_literal", 0, int'(ovr[0]), 255);

    // Reset mid-capture after 500 samples.
    rst[0] = 1'b1; step(); rst[0] = 1'b0;
    st[0] = 1'b1; step(); st[0] = 1'b0;
    for (int i = 0; i < 500; i++) begin
      sv[0] = 1'b1; step(); sv[0] = 1'b0; step();
    end
    chk("mid_waddr_literal", 0, int'(waddr[0]), 500);
    rst[0] = 1'b1; sv[0] = 1'b1; step(); rst[0] = 1'b0;
    @(negedge clk);
    chk("rst_busy_literal",  0, int'(busy[0]),  0);
    chk("rst_waddr_literal", 0, int'(waddr[0]), 0);
    chk("rst_we_literal",    0, int'(we[0]),    0);
    chk("rst_ovr_literal",   0, int'(ovr[0]),   0);
    step();
    sv[0] = 1'b0;
    clr_log(0);
    st[0] = 1'b1; step(); st[0] = 1'b0;
    sv[0] = 1'b1; step(); sv[0] = 1'b0; step();
    chk("restart_writes",   0, wr_cnt[0],   1);
    chk("restart_addr0",    0, addr_bad[0], 0);
    chk("restart_waddr",    0, int'(waddr[0]), 1);
    rst[0] = 1'b1; step(); rst[0] = 1'b0;

    // Small frame: back-to-back samples, then the FFT never answers.
    clr_log(1);
    st[1] = 1'b1; step(); st[1] = 1'b0;
    for (int i = 0; i < 4; i++) begin sv[1] = 1'b1; step(); end
    sv[1] = 1'b0;
    for (int k = 0; k < 40 && to_cnt[1] == 0; k++) step();
    step();
    chk("b2b_writes_literal",  1, wr_cnt[1],   4);
    chk("b2b_addr_order",      1, addr_bad[1], 0);
    chk("b2b_fft_start_cyc",   1, fs_cyc[1],   last_wr_cyc[1] + 1);
    chk("timeout_seen",        1, to_cnt[1],   1);
    chk("timeout_latency_literal", 1, to_cyc[1] - (fs_cyc[1] + 1), 16);
    chk("timeout_no_frame",    1, fr_cnt[1],   0);
    chk("timeout_busy_after",  1, int'(busy[1]), 0);

    // Stray fft_done in IDLE must not disturb anything.
    w_before = waddr[1];
    clr_log(1);
    dn[1] = 1'b1; step(); step(); step(); dn[1] = 1'b0; step();
    chk("stray_busy",  1, int'(busy[1]),  0);
    chk("stray_waddr", 1, int'(waddr[1]), int'(w_before));
    chk("stray_ready", 1, fr_cnt[1], 0);
    chk("stray_fs",    1, fs_cnt[1], 0);
    chk("stray_to",    1, to_cnt[1], 0);

    // Randomized traffic on both instances against the reference model.
    for (int n = 0; n < 6000; n++) begin
      for (int d = 0; d < 2; d++) begin
        rst[d] = ($urandom_range(0, 399) == 0);
        st[d]  = ($urandom_range(0, 59) == 0);
        sv[d]  = (d == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) == 0);
        dn[d]  = ($urandom_range(0, 29) == 0);
      end
      step();
    end
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b0; st[d] = 1'b0; sv[d] = 1'b0; dn[d] = 1'b0;
    end
    step(); step();
    chk_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
